// File: rtl/spi_reg_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// spi_reg_slave
//
// SPI mode-0 slave that exposes a small byte-wide register bank. The SPI
// pins are asynchronous to clk and are oversampled via synchronizers; all
// logic runs on the rising edge of clk.
//
// Transaction framing (ss_n low):
//   byte 0     : command. bit7 = 1 read / 0 write, bits[ADDR_W-1:0] = start
//                address, remaining bits ignored.
//   bytes 1..N : data. Writes store each completed byte at the current
//                address. Reads shift bank bytes out on miso. The address
//                auto-increments and wraps at 2**ADDR_W.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   ss_n       SPI slave select, active low (async)
//   sclk       SPI clock, CPOL=0 / CPHA=0 (async)
//   mosi       serial data in, MSB first (async)
//   miso       serial data out, MSB first
//   miso_tri   1 = release miso, 0 = drive it (equals synchronized ss_n)
//   loc_addr   local read address into the bank
//   loc_rdata  registered bank[loc_addr], one cycle latency
//   wr_stb     one-cycle pulse per byte written over SPI
//   wr_addr    bank address of that write (valid with wr_stb)
//   wr_data    byte written (valid with wr_stb)
//   busy       1 while the synchronized ss_n is low
// ---------------------------------------------------------------------------
module spi_reg_slave #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_tri,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // Cycles after reset before an ss_n falling edge is trusted. The
    // synchronizer restarts at "deselected" on reset; if the master still
    // holds ss_n low, the chain draining to 0 would otherwise look like a
    // fresh select and restart a transaction mid-stream.
    localparam int ARM_CNT = SS + 2;
    localparam int ARM_W   = $clog2(ARM_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -----------------------------------------------------------------------
    logic [SS-1:0]    r_ss_sync;
    logic [SS-1:0]    r_sclk_sync;
    logic [SS-1:0]    r_mosi_sync;
    logic             r_ss_d;
    logic             r_sclk_d;
    logic [ARM_W-1:0] r_arm_cnt;

    logic w_ss_s;
    logic w_sclk_s;
    logic w_mosi_s;
    logic w_armed;
    logic w_ss_fall;
    logic w_sclk_rise;
    logic w_sclk_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
            r_arm_cnt   <= '0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SS-2:0], ss_n};
            r_sclk_sync <= {r_sclk_sync[SS-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SS-2:0], mosi};
            r_ss_d      <= w_ss_s;
            r_sclk_d    <= w_sclk_s;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
        end
    end

    assign w_ss_s   = r_ss_sync[SS-1];
    assign w_sclk_s = r_sclk_sync[SS-1];
    assign w_mosi_s = r_mosi_sync[SS-1];
    assign w_armed  = (r_arm_cnt == ARM_W'(ARM_CNT));

    assign w_ss_fall   = ~w_ss_s & r_ss_d & w_armed;
    // sclk activity only counts while selected.
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_d & ~w_ss_s;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_d & ~w_ss_s;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;

    logic [2:0]        r_bit_cnt;
    logic [6:0]        r_rx_shift;
    logic [7:0]        r_tx_shift;
    logic              r_miso;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load_pend;
    logic              r_wr_stb;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_loc_rdata;
    logic [7:0]        r_bank [DEPTH];

    logic       w_byte_done;
    logic [7:0] w_rx_byte;
    logic       w_wr_en;
    logic       w_tx_load;

    assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx_shift, w_mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_tx_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_ss_s) begin
                    w_state_next = ST_IDLE;
                end else if (w_byte_done) begin
                    w_state_next = w_rx_byte[7] ? ST_RD : ST_WR;
                end
            end
            ST_WR: begin
                w_wr_en = w_byte_done;
                if (w_ss_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                w_tx_load = w_sclk_fall & r_load_pend;
                if (w_ss_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift registers, address pointer and write strobe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_miso      <= 1'b0;
            r_addr      <= '0;
            r_load_pend <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_ss_s || r_state == ST_IDLE) begin
                // Deselected or waiting for select: any partial byte is dropped.
                r_bit_cnt   <= '0;
                r_load_pend <= 1'b0;
                r_tx_shift  <= '0;
                if (w_ss_fall) begin
                    r_rx_shift <= '0;
                    r_miso     <= 1'b0;
                end
            end else begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (w_byte_done && r_state == ST_CMD) begin
                        r_addr      <= w_rx_byte[ADDR_W-1:0];
                        // A read command fetches its first byte on the
                        // falling edge that follows the command's last bit.
                        r_load_pend <= w_rx_byte[7];
                    end
                    if (w_byte_done && r_state == ST_RD) begin
                        r_load_pend <= 1'b1;
                    end
                    if (w_wr_en) begin
                        r_wr_stb  <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= w_rx_byte;
                        r_addr    <= r_addr + ADDR_W'(1);
                    end
                end
                if (w_sclk_fall) begin
                    if (w_tx_load) begin
                        // MSB goes straight to miso; the rest waits in tx.
                        r_miso      <= r_bank[r_addr][7];
                        r_tx_shift  <= {r_bank[r_addr][6:0], 1'b0};
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_load_pend <= 1'b0;
                    end else begin
                        // tx holds zeros outside RD, so CMD/WR shift out 0x00.
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register bank with registered local read port. A same-cycle write
    // and local read of one address returns the old byte.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
            r_loc_rdata <= '0;
        end else begin
            if (w_wr_en) begin
                r_bank[r_addr] <= w_rx_byte;
            end
            r_loc_rdata <= r_bank[loc_addr];
        end
    end

    assign miso      = r_miso;
    assign miso_tri  = w_ss_s;
    assign busy      = ~w_ss_s;
    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign loc_rdata = r_loc_rdata;

endmodule

// File: tb/tb_spi_reg_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_spi_reg_slave
//
// Bench for spi_reg_slave. A bus-functional SPI master drives transactions;
// a plain-array model of the bank predicts every write strobe (queued for a
// separate monitor process) and every byte the master should receive.
// ---------------------------------------------------------------------------
module tb_spi_reg_slave;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int HALF   = 8;   // sclk half period in clk cycles

    logic              clk = 1'b0;
    logic              rst;
    logic              ss_n;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              miso_tri;
    logic [ADDR_W-1:0] loc_addr;
    logic [7:0]        loc_rdata;
    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;

    always #5 clk = ~clk;

    spi_reg_slave #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ss_n      (ss_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_tri  (miso_tri),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] old;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] model [DEPTH];
    logic [7:0] txd [8];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write-strobe monitor: pops the next predicted write for each strobe.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && wr_stb === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected_stb", 32'(wr_stb), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    $display("wr_stb addr=%0d data=%02h", wr_addr, wr_data);
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    if (loc_addr == e.addr) begin
                        check("loc_same_cycle_old", 32'(loc_rdata), 32'(e.old));
                        @(negedge clk);
                        check("loc_next_cycle_new", 32'(loc_rdata), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Shift nbits of tx (MSB first); rx collects miso sampled at each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic ss_start();
        ss_n = 1'b0;
        wait_clk(HALF);
        check("busy_selected", 32'(busy), 32'd1);
        check("tri_selected", 32'(miso_tri), 32'd0);
    endtask

    task automatic ss_end();
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(2 * HALF);
        check("tri_released", 32'(miso_tri), 32'd1);
        check("busy_released", 32'(busy), 32'd0);
        check("wr_pending", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic loc_check(input logic [3:0] a);
        loc_addr = a;
        wait_clk(2);
        check("loc_rdata", 32'(loc_rdata), 32'(model[a]));
    endtask

    // Full transaction: command, ndata data bytes from txd, optional trailing
    // partial byte. Expectations come from the bank model.
    task automatic spi_txn(input logic [7:0] cmd, input int ndata, input int partial);
        logic [7:0] rx;
        logic [3:0] a;
        $display("txn cmd=%02h ndata=%0d partial=%0d", cmd, ndata, partial);
        ss_start();
        spi_bits(cmd, 8, rx);
        check("cmd_miso", 32'(rx), 32'h00);
        a = cmd[3:0];
        for (int k = 0; k < ndata; k++) begin
            if (!cmd[7]) begin
                exp_wr.push_back('{a, txd[k], model[a]});
                model[a] = txd[k];
                spi_bits(txd[k], 8, rx);
                check("wr_miso", 32'(rx), 32'h00);
            end else begin
                spi_bits(txd[k], 8, rx);
                check("rd_byte", 32'(rx), 32'(model[a]));
            end
            a = a + 4'd1;
        end
        if (partial > 0) begin
            spi_bits(8'($urandom), partial, rx);
        end
        ss_end();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] cmd;
        int         nd;
        int         part;

        rst      = 1'b1;
        ss_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        loc_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        // Reset values
        wait_clk(3);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_tri", 32'(miso_tri), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
        rst = 1'b0;
        wait_clk(2);
        for (int i = 0; i < DEPTH; i++) loc_check(4'(i));

        // Write burst, local readback, same-cycle read behaviour at addr 2
        loc_addr = 4'd2;
        txd[0] = 8'hA5; txd[1] = 8'h3C;
        spi_txn(8'h02, 2, 0);
        loc_check(4'd3);

        // Read burst with two dummy bytes
        txd[0] = 8'hFF; txd[1] = 8'h00;
        spi_txn(8'h82, 2, 0);

        // Address wrap, write then read
        loc_addr = 4'd0;
        txd[0] = 8'h11; txd[1] = 8'h22;
        spi_txn(8'h0F, 2, 0);
        spi_txn(8'h8F, 2, 0);

        // Abort mid data byte: no strobe, bank[5] unchanged
        spi_txn(8'h05, 0, 4);
        loc_check(4'd5);

        // Incomplete command byte, then a normal write to the same address
        $display("txn partial command");
        ss_start();
        spi_bits(8'h07, 5, rx);
        ss_end();
        txd[0] = 8'h5A;
        spi_txn(8'h07, 1, 0);
        loc_check(4'd7);

        // sclk toggling while deselected
        $display("idle sclk pulses");
        for (int i = 0; i < 16; i++) begin
            mosi = 1'($urandom);
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            if (i % 4 == 3) begin
                check("idle_tri", 32'(miso_tri), 32'd1);
                check("idle_busy", 32'(busy), 32'd0);
            end
        end
        check("idle_wr_pending", 32'(exp_wr.size()), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            cmd  = 8'($urandom);
            nd   = $urandom_range(1, 4);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 8; k++) txd[k] = 8'($urandom);
            loc_addr = 4'($urandom);
            spi_txn(cmd, nd, part);
            loc_check(4'($urandom));
        end

        // Reset during the 2nd data byte of a write
        txd[0] = 8'h99;
        spi_txn(8'h00, 1, 0);
        $display("txn write with reset in 2nd data byte");
        loc_addr = 4'd3;
        ss_start();
        spi_bits(8'h01, 8, rx);
        check("cmd_miso", 32'(rx), 32'h00);
        exp_wr.push_back('{4'd1, 8'h77, model[1]});
        model[1] = 8'h77;
        spi_bits(8'h77, 8, rx);
        spi_bits(8'hC3, 4, rx);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_wr_stb", 32'(wr_stb), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check("mid_rst_miso", 32'(miso), 32'd0);
        check("mid_rst_miso_tri", 32'(miso_tri), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_loc_rdata", 32'(loc_rdata), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        spi_bits(8'h3C, 4, rx);
        ss_end();
        loc_check(4'd3);
        loc_check(4'd1);
        txd[0] = 8'h00;
        spi_txn(8'h80, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter ADDR_W, default 4, sets address width; the register bank holds 2**ADDR_W bytes.
REQ-002 Parameter SYNC_STAGES, default 2, sets synchronizer depth on ss_n, sclk and mosi (minimum 2).
REQ-003 Port clk  input  1  the single system clock; all logic on the rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port ss_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-006 Port sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 Port mosi  input  1  serial data in, MSB first.
REQ-008 Port miso  output  1  serial data out, MSB first.
REQ-009 Port miso_tri  output  1  1 = miso released (high-Z at the top level); 0 = drive miso.
REQ-010 Port loc_addr  input  ADDR_W  local read address into the register bank.
REQ-011 Port loc_rdata  output  8  registered bank[loc_addr], valid 1 cycle after loc_addr.
REQ-012 Port wr_stb  output  1  one-cycle pulse for each byte written over SPI.
REQ-013 Port wr_addr  output  ADDR_W  bank address of the write; valid with wr_stb.
REQ-014 Port wr_data  output  8  byte written; valid with wr_stb.
REQ-015 Port busy  output  1  1 while the synchronized ss_n is low.

Function
REQ-016 The block shall sample mosi on each synchronized sclk rising edge and update miso on each synchronized sclk falling edge.
REQ-017 sclk high and low phases shall each be at least SYNC_STAGES+2 clk periods; shorter phases are unsupported.
REQ-018 Transaction framing: byte 0 = command (bit7 = 1 read / 0 write; bits[ADDR_W-1:0] = start address; other bits ignored); bytes 1..N = data.
REQ-019 FSM states: IDLE, CMD, WR, RD; IDLE->CMD on the ss_n falling edge; CMD->WR or CMD->RD after the 8th bit of the command byte.
REQ-020 In WR: each completed byte writes bank[addr]; wr_stb pulses 1 cycle with wr_addr=addr and wr_data=byte; the cycle after the strobe, addr = addr+1 mod 2**ADDR_W.
REQ-021 In RD: bank[addr] loads into the TX shift register on the falling edge after the 8th bit of the previous byte; addr increments mod 2**ADDR_W per byte.
REQ-022 During CMD, and in WR, miso shall shift out 8'h00.
REQ-023 miso_tri shall equal the synchronized ss_n: 0 while selected, 1 otherwise.
REQ-024 Synchronized ss_n rising in any state -> IDLE the next cycle; a partial byte is discarded with no wr_stb; bit counter cleared.
REQ-025 An incomplete command byte shall cause no write and no address change.
REQ-026 A local read of an address written in the same cycle shall return the old value; the new value appears on the following cycle.
REQ-027 Address wrap: after address 2**ADDR_W-1, the next data byte uses address 0.
REQ-028 sclk edges while ss_n is high shall be ignored.

Reset
REQ-029 On rst: FSM=IDLE; bit counter=0; miso=0; miso_tri=1; wr_stb=0; wr_addr=0; wr_data=0; busy=0; loc_rdata=0; all bank bytes = 8'h00.
REQ-030 rst asserted mid-transaction shall abort it; the block shall stay in IDLE until a new ss_n falling edge follows rst deassertion.

Verification
REQ-031 Write burst: cmd 8'h02, data 8'hA5, 8'h3C -> wr_stb twice, (2,A5) then (3,3C); loc_addr=3 -> loc_rdata=8'h3C.
REQ-032 Read burst after REQ-031: cmd 8'h82 plus 2 dummy bytes -> master receives 8'h00, 8'hA5, 8'h3C; miso_tri=0 only while ss_n is low.
REQ-033 Wrap: cmd 8'h0F, data 8'h11, 8'h22 -> writes (15,11), (0,22); read cmd 8'h8F -> 8'h11, 8'h22.
REQ-034 Abort: cmd 8'h05, then 4 bits of data, then ss_n high -> no wr_stb; bank[5] unchanged; FSM back in IDLE.
REQ-035 Reset: rst pulsed during the 2nd data byte of a write -> all outputs at reset values; a following read of 8'h80 returns 8'h00.
REQ-036 Idle sclk: 16 sclk pulses with ss_n high -> no wr_stb, miso_tri=1, busy=0.
